// File: rtl/router_pkg.sv
// Shared mesh-router types: flit layout, port/state encodings and the XY route helper.
// Used by every input port and by the bench model.
package router_pkg;

   localparam int unsigned FLIT_DATA_BITS   = 16;
   localparam int unsigned NUM_OF_FLITS     = 4;
   localparam int unsigned COORD_BITS       = FLIT_DATA_BITS / 2;
   localparam int unsigned INPUT_FIFO_DEPTH = NUM_OF_FLITS;

   typedef enum logic [1:0] {
      NONE_FLIT = 2'd0,
      HEAD_FLIT = 2'd1,
      BODY_FLIT = 2'd2,
      TAIL_FLIT = 2'd3
   } FLIT_TYPE_t;

   // Body and tail flits carry payload in the xaddr/yaddr fields.
   typedef struct packed {
      logic                  valid;
      FLIT_TYPE_t            ftype;
      logic [COORD_BITS-1:0] xaddr;
      logic [COORD_BITS-1:0] yaddr;
   } FLIT_HEAD_t;

   typedef struct packed {
      FLIT_HEAD_t head;
   } FLIT_t;

   typedef enum logic [2:0] {
      LOCAL = 3'd0,
      NORTH = 3'd1,
      SOUTH = 3'd2,
      EAST  = 3'd3,
      WEST  = 3'd4,
      NONE  = 3'd7
   } PORT_T;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ROUTING = 2'd1,
      ACTIVE  = 2'd2,
      WAITING = 2'd3
   } GLOBAL_STATE_t;

   typedef struct packed {
      logic [COORD_BITS-1:0] xaddr;
      logic [COORD_BITS-1:0] yaddr;
   } ROUTER_CONFIG;

   // Dimension-order routing: resolve X fully before moving in Y.
   function automatic PORT_T xy_route(input ROUTER_CONFIG self, input FLIT_HEAD_t h);
      PORT_T p;
      if (h.xaddr > self.xaddr) begin
         p = EAST;
      end else if (h.xaddr < self.xaddr) begin
         p = WEST;
      end else if (h.yaddr > self.yaddr) begin
         p = NORTH;
      end else if (h.yaddr < self.yaddr) begin
         p = SOUTH;
      end else begin
         p = LOCAL;
      end
      return p;
   endfunction

endpackage

// File: rtl/router_flit_fifo.sv
// Flit FIFO for one router input: extra pointer MSB distinguishes full from empty.
module router_flit_fifo
   import router_pkg::*;
#(
   parameter int unsigned DEPTH = INPUT_FIFO_DEPTH
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  push,
   input  FLIT_t push_data,
   input  logic  pop,
   output logic  full,
   output logic  empty,
   output FLIT_t head
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned PW = IW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("router_flit_fifo: DEPTH must be a power of two and at least 2");
   end

   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   FLIT_t         mem_q [DEPTH];
   logic          do_push, do_pop;

   assign full    = (wr_ptr_q[IW] != rd_ptr_q[IW]) && (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_ptr_q[IW-1:0]];

   // Storage is cleared too so the head output reads zero straight out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q[IW-1:0]] <= push_data;
            wr_ptr_q                <= wr_ptr_q + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
      end
   end

endmodule

// File: rtl/router_input_port.sv
// Router input stage: buffers upstream flits, computes the XY route from each head flit
// and streams the packet to the crossbar until its tail leaves.
module router_input_port
   import router_pkg::*;
#(
   parameter int unsigned DEPTH = INPUT_FIFO_DEPTH,
   parameter int unsigned AW    = FLIT_DATA_BITS / 2
) (
   input  logic          clk,
   input  logic          rst,
   input  ROUTER_CONFIG  cfg,
   input  FLIT_t         flit_in,
   input  logic          flit_in_valid,
   output logic          flit_in_ready,
   output PORT_T         route,
   output logic          switch_req,
   output FLIT_t         flit_out,
   output logic          flit_out_valid,
   input  logic          flit_out_ready,
   output GLOBAL_STATE_t state,
   output logic          proto_err
);

   if (AW != COORD_BITS) begin : g_aw_check
      $error("router_input_port: AW must equal the ROUTER_CONFIG coordinate width");
   end

   FLIT_t         fifo_head;
   logic          fifo_full, fifo_empty;
   logic          push, pop;
   GLOBAL_STATE_t state_q, state_d;
   PORT_T         route_q, route_d;
   logic          first_q, first_d;
   logic          err_q, err_d;
   logic          fwd_valid;

   // Invalid and NONE flits are dropped at the door and never occupy a slot.
   assign push = flit_in_valid && flit_in.head.valid && (flit_in.head.ftype != NONE_FLIT) &&
                 !fifo_full;
   assign flit_in_ready = !fifo_full;

   router_flit_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_data(flit_in),
      .pop      (pop),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .head     (fifo_head)
   );

   always_comb begin
      state_d    = state_q;
      route_d    = route_q;
      first_d    = first_q;
      err_d      = 1'b0;
      pop        = 1'b0;
      switch_req = 1'b0;
      fwd_valid  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               if (fifo_head.head.ftype == HEAD_FLIT) begin
                  state_d = ROUTING;
               end else begin
                  // Stray body/tail with no packet open: discard it.
                  pop   = 1'b1;
                  err_d = 1'b1;
               end
            end
         end
         ROUTING: begin
            route_d = xy_route(cfg, fifo_head.head);
            first_d = 1'b1;
            state_d = ACTIVE;
         end
         ACTIVE: begin
            switch_req = 1'b1;
            fwd_valid  = !fifo_empty;
            if (fwd_valid && flit_out_ready) begin
               pop     = 1'b1;
               first_d = 1'b0;
               // A second head inside an open packet is passed on as data but flagged.
               if (fifo_head.head.ftype == HEAD_FLIT && !first_q) begin
                  err_d = 1'b1;
               end
               if (fifo_head.head.ftype == TAIL_FLIT) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         route_q <= NONE;
         first_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         route_q <= route_d;
         first_q <= first_d;
         err_q   <= err_d;
      end
   end

   assign state          = state_q;
   assign route          = route_q;
   assign proto_err      = err_q;
   assign flit_out       = fifo_head;
   assign flit_out_valid = fwd_valid;

endmodule

// File: tb/tb_router_input_port.sv
// Self-checking bench for router_input_port: random payloads and destinations checked
// against a packet-level model of which flits leave, when, and with what route.
module tb_router_input_port;
   import router_pkg::*;

   logic          clk = 1'b0;
   logic          rst;
   ROUTER_CONFIG  cfg;
   FLIT_t         flit_in;
   logic          flit_in_valid;
   logic          flit_in_ready;
   PORT_T         route;
   logic          switch_req;
   FLIT_t         flit_out;
   logic          flit_out_valid;
   logic          flit_out_ready;
   GLOBAL_STATE_t state;
   logic          proto_err;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   FLIT_t in_q[$], out_q[$], exp_q[$];
   int    out_cyc[$], err_cyc[$], gaps[$];
   int    exp_err;
   int    low_run = 0;
   bit    seen_high = 1'b0;

   router_input_port #(
      .DEPTH(4),
      .AW   (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cfg           (cfg),
      .flit_in       (flit_in),
      .flit_in_valid (flit_in_valid),
      .flit_in_ready (flit_in_ready),
      .route         (route),
      .switch_req    (switch_req),
      .flit_out      (flit_out),
      .flit_out_valid(flit_out_valid),
      .flit_out_ready(flit_out_ready),
      .state         (state),
      .proto_err     (proto_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Observe accepted inputs, departing flits, error pulses and switch_req low runs.
   always @(negedge clk) begin
      if (!rst) begin
         if (flit_in_valid && flit_in.head.valid && flit_in.head.ftype != NONE_FLIT &&
             flit_in_ready)
            in_q.push_back(flit_in);
         if (flit_out_valid && flit_out_ready) begin
            out_q.push_back(flit_out);
            out_cyc.push_back(cyc);
         end
         if (proto_err) err_cyc.push_back(cyc);
         if (switch_req) begin
            if (seen_high && low_run > 0) gaps.push_back(low_run);
            low_run   = 0;
            seen_high = 1'b1;
         end else begin
            low_run++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   function automatic FLIT_t mk(input FLIT_TYPE_t t, input int x, input int y);
      FLIT_t f;
      f.head.valid = 1'b1;
      f.head.ftype = t;
      f.head.xaddr = 8'(x);
      f.head.yaddr = 8'(y);
      return f;
   endfunction

   function automatic FLIT_t rnd_body(input FLIT_TYPE_t t);
      return mk(t, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
   endfunction

   function automatic PORT_T ref_route(input int cx, input int cy, input int dx, input int dy);
      if (dx > cx) return EAST;
      if (dx < cx) return WEST;
      if (dy > cy) return NORTH;
      if (dy < cy) return SOUTH;
      return LOCAL;
   endfunction

   // Packet-level model: outside a packet only a HEAD opens one, anything else is a
   // dropped stray; inside, every flit is forwarded and a TAIL closes the packet.
   function automatic void model_build(input int base);
      bit inpkt = 1'b0;
      exp_q.delete();
      exp_err = 0;
      for (int i = base; i < in_q.size(); i++) begin
         if (!inpkt) begin
            if (in_q[i].head.ftype == HEAD_FLIT) begin
               exp_q.push_back(in_q[i]);
               inpkt = 1'b1;
            end else begin
               exp_err++;
            end
         end else begin
            exp_q.push_back(in_q[i]);
            if (in_q[i].head.ftype == HEAD_FLIT) exp_err++;
            if (in_q[i].head.ftype == TAIL_FLIT) inpkt = 1'b0;
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds the flit on the link until an edge where ready was high.
   task automatic send_flit(input FLIT_t f);
      bit acc = 1'b0;
      flit_in       = f;
      flit_in_valid = 1'b1;
      for (int n = 0; n < 40 && !acc; n++) begin
         @(negedge clk);
         acc = flit_in_ready;
         @(posedge clk);
         #1;
      end
      flit_in_valid = 1'b0;
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL send_flit: flit_in_ready got 0 for 40 cycles, required 1");
      end
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (state !== IDLE) begin
         errors++; $display("FAIL reset_state: got %0d required %0d", state, IDLE);
      end
      checks++;
      if (flit_in_ready !== 1'b1 || switch_req !== 1'b0 || flit_out_valid !== 1'b0 ||
          proto_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got rdy=%b req=%b ov=%b err=%b required 1 0 0 0",
                  flit_in_ready, switch_req, flit_out_valid, proto_err);
      end
      checks++;
      if (route !== NONE) begin
         errors++; $display("FAIL reset_route: got %0d required %0d", route, NONE);
      end
      checks++;
      if (flit_out !== '0) begin
         errors++; $display("FAIL reset_flit_out: got %h required 0", flit_out);
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      int    ib = in_q.size(), ob = out_q.size(), eb = err_cyc.size();
      int    t0;
      FLIT_t h = mk(HEAD_FLIT, 5, 1);
      cfg.xaddr = 8'd2; cfg.yaddr = 8'd2;
      flit_out_ready = 1'b1;
      send_flit(h);
      t0 = cyc;
      send_flit(rnd_body(BODY_FLIT));
      send_flit(rnd_body(BODY_FLIT));
      checks++;
      if (state !== ACTIVE || route !== EAST || switch_req !== 1'b1 || flit_out_valid !== 1'b1) begin
         errors++;
         $display("FAIL single_active: got st=%0d rt=%0d req=%b ov=%b required %0d %0d 1 1",
                  state, route, switch_req, flit_out_valid, ACTIVE, EAST);
      end
      checks++;
      if (flit_out !== h) begin
         errors++; $display("FAIL single_head_out: got %h required %h", flit_out, h);
      end
      send_flit(rnd_body(TAIL_FLIT));
      while (cyc < t0 + 6) tick();
      checks++;
      if (state !== IDLE || switch_req !== 1'b0) begin
         errors++;
         $display("FAIL single_idle: got st=%0d req=%b required %0d 0", state, switch_req, IDLE);
      end
      tick();
      model_build(ib);
      checks++;
      if (out_q.size() - ob != exp_q.size()) begin
         errors++;
         $display("FAIL single_count: got %0d flits required %0d", out_q.size() - ob, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && ob + i < out_q.size(); i++) begin
         checks++;
         if (out_q[ob+i] !== exp_q[i] || out_cyc[ob+i] != t0 + 2 + i) begin
            errors++;
            $display("FAIL single_flit[%0d]: got %h@%0d required %h@%0d", i, out_q[ob+i],
                     out_cyc[ob+i], exp_q[i], t0 + 2 + i);
         end
      end
      checks++;
      if (err_cyc.size() - eb != exp_err) begin
         errors++;
         $display("FAIL single_err: got %0d pulses required %0d", err_cyc.size() - eb, exp_err);
      end
   endtask

   task automatic test_routes();
      int    dx[8] = '{1, 3, 3, 3, 0, 0, 0, 0};
      int    dy[8] = '{9, 7, 0, 3, 0, 0, 0, 0};
      PORT_T ex[8] = '{WEST, NORTH, SOUTH, LOCAL, NONE, NONE, NONE, NONE};
      cfg.xaddr = 8'd3; cfg.yaddr = 8'd3;
      flit_out_ready = 1'b1;
      for (int i = 4; i < 8; i++) begin
         dx[i] = int'($urandom_range(0, 7));
         dy[i] = int'($urandom_range(0, 7));
         ex[i] = ref_route(3, 3, dx[i], dy[i]);
      end
      for (int i = 0; i < 8; i++) begin
         send_flit(mk(HEAD_FLIT, dx[i], dy[i]));
         send_flit(rnd_body(TAIL_FLIT));
         repeat (4) tick();
         checks++;
         if (route !== ex[i]) begin
            errors++;
            $display("FAIL route[%0d] to (%0d,%0d): got %0d required %0d", i, dx[i], dy[i],
                     route, ex[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int    ib = in_q.size(), ob = out_q.size(), eb = err_cyc.size();
      int    tr;
      FLIT_t h = mk(HEAD_FLIT, 0, 0);
      cfg.xaddr = 8'd1; cfg.yaddr = 8'd1;
      flit_out_ready = 1'b0;
      send_flit(h);
      send_flit(rnd_body(BODY_FLIT));
      send_flit(rnd_body(BODY_FLIT));
      send_flit(rnd_body(TAIL_FLIT));
      checks++;
      if (flit_in_ready !== 1'b0) begin
         errors++; $display("FAIL bp_full: flit_in_ready got %b required 0", flit_in_ready);
      end
      checks++;
      if (state !== ACTIVE || switch_req !== 1'b1 || flit_out_valid !== 1'b1 || flit_out !== h) begin
         errors++;
         $display("FAIL bp_stall: got st=%0d req=%b ov=%b out=%h required %0d 1 1 %h",
                  state, switch_req, flit_out_valid, flit_out, ACTIVE, h);
      end
      flit_in       = mk(HEAD_FLIT, 2, 2);
      flit_in_valid = 1'b1;
      repeat (3) tick();
      checks++;
      if (flit_in_ready !== 1'b0) begin
         errors++; $display("FAIL bp_fifth: flit_in_ready got %b required 0", flit_in_ready);
      end
      flit_in_valid  = 1'b0;
      flit_out_ready = 1'b1;
      tr = cyc;
      tick();
      checks++;
      if (flit_in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_ready_back: flit_in_ready got %b required 1", flit_in_ready);
      end
      repeat (6) tick();
      model_build(ib);
      checks++;
      if (out_q.size() - ob != exp_q.size() || exp_q.size() != 4) begin
         errors++;
         $display("FAIL bp_count: got %0d flits required 4 (model %0d)", out_q.size() - ob,
                  exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && ob + i < out_q.size(); i++) begin
         checks++;
         if (out_q[ob+i] !== exp_q[i] || out_cyc[ob+i] != tr + i) begin
            errors++;
            $display("FAIL bp_flit[%0d]: got %h@%0d required %h@%0d", i, out_q[ob+i],
                     out_cyc[ob+i], exp_q[i], tr + i);
         end
      end
      checks++;
      if (err_cyc.size() - eb != exp_err) begin
         errors++;
         $display("FAIL bp_err: got %0d pulses required %0d", err_cyc.size() - eb, exp_err);
      end
   endtask

   task automatic test_stray();
      int    ib = in_q.size(), ob = out_q.size(), eb = err_cyc.size();
      int    te;
      FLIT_t f;
      cfg.xaddr = 8'd2; cfg.yaddr = 8'd2;
      flit_out_ready = 1'b1;
      send_flit(rnd_body(BODY_FLIT));
      te = cyc;
      f = mk(HEAD_FLIT, 7, 7);
      f.head.valid = 1'b0;
      send_flit(f);
      send_flit(mk(NONE_FLIT, 6, 6));
      send_flit(mk(HEAD_FLIT, 0, 4));
      send_flit(rnd_body(BODY_FLIT));
      send_flit(rnd_body(TAIL_FLIT));
      repeat (8) tick();
      checks++;
      if (route !== WEST) begin
         errors++; $display("FAIL stray_route: got %0d required %0d", route, WEST);
      end
      model_build(ib);
      checks++;
      if (err_cyc.size() - eb != exp_err || exp_err != 1) begin
         errors++;
         $display("FAIL stray_err: got %0d pulses required 1 (model %0d)", err_cyc.size() - eb,
                  exp_err);
      end else begin
         checks++;
         if (err_cyc[eb] != te + 1) begin
            errors++;
            $display("FAIL stray_err_cycle: got %0d required %0d", err_cyc[eb], te + 1);
         end
      end
      checks++;
      if (out_q.size() - ob != exp_q.size()) begin
         errors++;
         $display("FAIL stray_count: got %0d flits required %0d", out_q.size() - ob, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && ob + i < out_q.size(); i++) begin
         checks++;
         if (out_q[ob+i] !== exp_q[i]) begin
            errors++;
            $display("FAIL stray_flit[%0d]: got %h required %h", i, out_q[ob+i], exp_q[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int ib = in_q.size(), ob = out_q.size(), eb = err_cyc.size(), gb = gaps.size();
      int lx = 0, ly = 0;
      cfg.xaddr = 8'd4; cfg.yaddr = 8'd4;
      flit_out_ready = 1'b1;
      for (int p = 0; p < 3; p++) begin
         lx = int'($urandom_range(0, 7));
         ly = int'($urandom_range(0, 7));
         send_flit(mk(HEAD_FLIT, lx, ly));
         send_flit(rnd_body(BODY_FLIT));
         send_flit(rnd_body(BODY_FLIT));
         send_flit(rnd_body(TAIL_FLIT));
      end
      repeat (20) tick();
      checks++;
      if (route !== ref_route(4, 4, lx, ly)) begin
         errors++;
         $display("FAIL b2b_route: got %0d required %0d", route, ref_route(4, 4, lx, ly));
      end
      model_build(ib);
      checks++;
      if (out_q.size() - ob != exp_q.size() || exp_q.size() != 12) begin
         errors++;
         $display("FAIL b2b_count: got %0d flits required 12 (model %0d)", out_q.size() - ob,
                  exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && ob + i < out_q.size(); i++) begin
         checks++;
         if (out_q[ob+i] !== exp_q[i]) begin
            errors++;
            $display("FAIL b2b_flit[%0d]: got %h required %h", i, out_q[ob+i], exp_q[i]);
         end
      end
      checks++;
      if (err_cyc.size() - eb != exp_err) begin
         errors++;
         $display("FAIL b2b_err: got %0d pulses required %0d", err_cyc.size() - eb, exp_err);
      end
      // First recorded gap is the idle time before this test's first packet.
      checks++;
      if (gaps.size() != gb + 3) begin
         errors++;
         $display("FAIL b2b_gap_count: got %0d gaps required 3", gaps.size() - gb);
      end else begin
         for (int i = 1; i < 3; i++) begin
            checks++;
            if (gaps[gb+i] != 2) begin
               errors++;
               $display("FAIL b2b_gap[%0d]: switch_req low got %0d cycles required 2", i,
                        gaps[gb+i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int ib, ob, eb;
      cfg.xaddr = 8'd4; cfg.yaddr = 8'd4;
      flit_out_ready = 1'b1;
      send_flit(mk(HEAD_FLIT, 1, 4));
      send_flit(rnd_body(BODY_FLIT));
      send_flit(rnd_body(BODY_FLIT));
      tick();
      checks++;
      if (switch_req !== 1'b1 || route !== WEST) begin
         errors++;
         $display("FAIL rm_pre: got req=%b rt=%0d required 1 %0d", switch_req, route, WEST);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (state !== IDLE || flit_in_ready !== 1'b1 || switch_req !== 1'b0 ||
          flit_out_valid !== 1'b0 || proto_err !== 1'b0) begin
         errors++;
         $display("FAIL rm_async: got st=%0d rdy=%b req=%b ov=%b err=%b required %0d 1 0 0 0",
                  state, flit_in_ready, switch_req, flit_out_valid, proto_err, IDLE);
      end
      checks++;
      if (route !== NONE || flit_out !== '0) begin
         errors++;
         $display("FAIL rm_async_data: got rt=%0d out=%h required %0d 0", route, flit_out, NONE);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      tick();
      ib = in_q.size(); ob = out_q.size(); eb = err_cyc.size();
      send_flit(mk(HEAD_FLIT, 6, 2));
      send_flit(rnd_body(TAIL_FLIT));
      repeat (6) tick();
      checks++;
      if (route !== EAST) begin
         errors++; $display("FAIL rm_route: got %0d required %0d", route, EAST);
      end
      model_build(ib);
      checks++;
      if (out_q.size() - ob != exp_q.size() || err_cyc.size() - eb != exp_err) begin
         errors++;
         $display("FAIL rm_residual: got %0d flits %0d errs required %0d flits %0d errs",
                  out_q.size() - ob, err_cyc.size() - eb, exp_q.size(), exp_err);
      end
      for (int i = 0; i < exp_q.size() && ob + i < out_q.size(); i++) begin
         checks++;
         if (out_q[ob+i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rm_flit[%0d]: got %h required %h", i, out_q[ob+i], exp_q[i]);
         end
      end
   endtask

   initial begin
      rst            = 1'b0;
      cfg            = '0;
      flit_in        = '0;
      flit_in_valid  = 1'b0;
      flit_out_ready = 1'b0;
      #1;
      rst = 1'b1;
      test_reset();
      test_single();
      test_routes();
      test_backpressure();
      test_stray();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
